// File: rtl/a429_pkg.sv
// a429_pkg: shared word width, transmitter state type and parity helper for the ARINC 429 TX path.
package a429_pkg;
  localparam int A429_WORD_W = 32;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} a429_state_e;
  function automatic logic a429_odd_par(input logic [30:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/a429_bit_timer.sv
// a429_bit_timer: half-bit tick generator; phase 0 = HIGH half, 1 = NULL half, restarts whenever run is low.
module a429_bit_timer #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic half_tick,
  output logic phase
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  assign half_tick = run & (cnt_q == CW'(DIV - 1));
  assign phase = phase_q;
  always_comb begin
    cnt_d = (~run | half_tick) ? '0 : cnt_q + CW'(1);
    phase_d = run & (phase_q ^ half_tick);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/a429_tx_ser.sv
// a429_tx_ser: ARINC 429 bipolar RZ transmit serializer fed from a word FIFO.
// Define A429_TX_PARITY_EN to replace bit 32 with odd parity at latch time.
module a429_tx_ser
  import a429_pkg::*;
#(
  parameter int DIV = 25,
  parameter int GAP_BITS = 4,
  parameter bit FWFT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_et,
  input  logic [A429_WORD_W-1:0] fifo_do,
  input  logic                   fifo_vl,
  output logic                   fifo_re,
  output logic                   tx_a,
  output logic                   tx_b,
  output logic                   busy,
  output logic                   word_done,
  output logic [15:0]            word_cnt
);
  localparam int GAP_LEN = GAP_BITS * 2 * DIV;
  localparam int GW = GAP_LEN > 1 ? $clog2(GAP_LEN) : 1;
  a429_state_e state_q, state_d;
  logic [A429_WORD_W-1:0] sh_q, sh_d, load_word;
  logic [4:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, tx_a_q, tx_a_d, tx_b_q, tx_b_d;
  logic run, half_tick, phase, phase_nx, bit_end, pop;
`ifdef A429_TX_PARITY_EN
  assign load_word = {a429_odd_par(fifo_do[30:0]), fifo_do[30:0]};
`else
  assign load_word = fifo_do;
`endif
  assign run = state_q == SHIFT;
  assign bit_end = half_tick & phase;
  assign pop = ~rst & (state_q == IDLE) & en & ~fifo_et;
  assign fifo_re = pop;
  assign busy = state_q != IDLE;
  assign tx_a = tx_a_q;
  assign tx_b = tx_b_q;
  assign word_done = done_q;
  assign word_cnt = cnt_q;
  a429_bit_timer #(.DIV(DIV)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(run),
    .half_tick(half_tick),
    .phase(phase)
  );
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    gap_d = '0;
    cnt_d = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = FWFT ? SHIFT : FETCH;
          sh_d = FWFT ? load_word : sh_q;
          bit_d = '0;
        end
      end
      FETCH: begin
        state_d = fifo_vl ? SHIFT : IDLE;
        sh_d = fifo_vl ? load_word : sh_q;
        bit_d = '0;
      end
      SHIFT: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          state_d = (bit_q == 5'd31) ? GAP : SHIFT;
          bit_d = (bit_q == 5'd31) ? bit_q : bit_q + 5'd1;
          done_d = bit_q == 5'd31;
          cnt_d = (bit_q == 5'd31) ? cnt_q + 16'd1 : cnt_q;
        end
      end
      GAP: begin
        state_d = (gap_q == GW'(GAP_LEN - 1)) ? IDLE : GAP;
        gap_d = (gap_q == GW'(GAP_LEN - 1)) ? '0 : gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Lines are registered, so drive them from the phase and bit that the next cycle will see.
    phase_nx = run & (phase ^ half_tick);
    tx_a_d = (state_d == SHIFT) & ~phase_nx & sh_d[0];
    tx_b_d = (state_d == SHIFT) & ~phase_nx & ~sh_d[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      tx_a_q <= 1'b0;
      tx_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      tx_a_q <= tx_a_d;
      tx_b_q <= tx_b_d;
    end
  end
endmodule
